vec_cache_mshr_alloc: RTL
=========================

VEC_CACHE_MSHR_ALLOC -- requirements
Module: vec_cache_mshr_alloc

Interface
REQ-001 The module SHALL have parameter ENTRY_NUM, default 16, number of MSHR entries (>=2).
REQ-002 The module SHALL have parameter ENTRY_IDX_WIDTH, default 4, width of an entry index, equal to $clog2(ENTRY_NUM).
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have ports mshr_alloc_vld_0 / mshr_alloc_vld_1  output  1 each  allocation slot 0/1 offers a free entry.
REQ-006 The module SHALL have ports mshr_alloc_idx_0 / mshr_alloc_idx_1  output  ENTRY_IDX_WIDTH each  offered entry index.
REQ-007 The module SHALL have ports mshr_alloc_rdy_0 / mshr_alloc_rdy_1  input  1 each  request arbiter consumes the offered entry.
REQ-008 The module SHALL have ports mshr_rel_vld_0 / mshr_rel_vld_1  input  1 each  entry release strobe (two completion ports).
REQ-009 The module SHALL have ports mshr_rel_idx_0 / mshr_rel_idx_1  input  ENTRY_IDX_WIDTH each  index being released.
REQ-010 The module SHALL have port free_cnt  output  $clog2(ENTRY_NUM+1)  number of free entries.
REQ-011 The module SHALL have port alloc_err  output  1  sticky release-protocol error flag.

Function
REQ-012 State SHALL be an ENTRY_NUM-bit free bitmap (1 = free); all outputs SHALL be derived only from registered state, no combinational path from any input to any output.
REQ-013 mshr_alloc_idx_0 SHALL be the lowest free index; mshr_alloc_idx_1 SHALL be the second-lowest free index, always distinct from idx_0.
REQ-014 mshr_alloc_vld_0 SHALL be 1 iff free_cnt>=1; mshr_alloc_vld_1 SHALL be 1 iff free_cnt>=2; idx of an invalid slot SHALL be 0.
REQ-015 An allocation on slot k SHALL occur on a cycle with mshr_alloc_vld_k && mshr_alloc_rdy_k and SHALL clear that entry's bit at the next edge; rdy without vld SHALL be ignored.
REQ-016 Slots SHALL be independent: slot 1 MAY be consumed without slot 0; both consumed in one cycle SHALL clear two bits.
REQ-017 mshr_alloc_vld_k SHALL NOT depend on mshr_alloc_rdy_k (vld before rdy, arbiter may gate rdy on vld).
REQ-018 A release mshr_rel_vld_k SHALL set bit mshr_rel_idx_k at the next edge; a released entry SHALL first be offered the cycle after the release edge (1-cycle latency).
REQ-019 Both release ports active in the same cycle with different indices SHALL set both bits; with equal indices SHALL set the bit once and count as a double release.
REQ-020 Allocation and release in the same cycle SHALL both take effect; free_cnt next = free_cnt - allocs + distinct valid releases.
REQ-021 free_cnt SHALL be a registered counter updated with the bitmap and SHALL always equal the popcount of the bitmap; it SHALL never exceed ENTRY_NUM nor underflow.
REQ-022 Full (free_cnt=0): both vld=0, releases still accepted; free_cnt=1: only slot 0 valid.

Reset
REQ-023 When rst_n=0 at a rising edge, bitmap SHALL become all ones, free_cnt=ENTRY_NUM, alloc_err=0, regardless of concurrent rdy/rel inputs.
REQ-024 After reset, outputs SHALL be mshr_alloc_vld_0=1, idx_0=0, mshr_alloc_vld_1=1, idx_1=1; reset mid-operation SHALL discard all outstanding allocations.

Configuration
REQ-025 Macro VEC_CACHE_MSHR_ALLOC_CHK_EN defined: release of an already-free entry, release index >= ENTRY_NUM, or equal-index dual release SHALL set alloc_err (sticky until reset) and SHALL leave the bitmap and free_cnt unchanged for that offending release.
REQ-026 Macro undefined: alloc_err SHALL be tied 0; out-of-range releases SHALL be ignored; in-range releases SHALL set the bit unconditionally, with free_cnt still equal to bitmap popcount.

Verification
REQ-027 Reset then rdy_0=rdy_1=1 for 8 cycles (ENTRY_NUM=16) -> indices 0..15 allocated pairwise in order, free_cnt 16->0, both vld=0 in cycle 9.
REQ-028 Full state, rel_vld_0=1 idx=5 -> next cycle vld_0=1 idx_0=5, vld_1=0, free_cnt=1.
REQ-029 free_cnt=2 (entries 3,9 free), rdy_1=1 only, rel_vld_0=1 idx=0 same cycle -> next cycle idx_0=0, idx_1=3, free_cnt=2.
REQ-030 Dual release idx 7 and 12 with rdy_0=1 offering idx 2 -> free_cnt +1 net, bits 7,12 set, bit 2 cleared.
REQ-031 With VEC_CACHE_MSHR_ALLOC_CHK_EN, release idx 4 while free -> alloc_err=1 next cycle, free_cnt unchanged, stays 1 until rst_n=0.
REQ-032 Assert rst_n=0 mid-stream with rdy and rel active -> next cycle bitmap all free, free_cnt=16, idx_0=0, idx_1=1, alloc_err=0.

Source files
------------

// File: rtl/vec_cache_mshr_alloc.sv
// MSHR entry allocator: free bitmap offering the two lowest free entries per cycle, dual release ports.
// Optional release-protocol checking enabled by defining VEC_CACHE_MSHR_ALLOC_CHK_EN.
module vec_cache_mshr_alloc #(
   parameter int ENTRY_NUM       = 16,
   parameter int ENTRY_IDX_WIDTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   output logic                               mshr_alloc_vld_0,
   output logic                               mshr_alloc_vld_1,
   output logic [ENTRY_IDX_WIDTH-1:0]         mshr_alloc_idx_0,
   output logic [ENTRY_IDX_WIDTH-1:0]         mshr_alloc_idx_1,
   input  logic                               mshr_alloc_rdy_0,
   input  logic                               mshr_alloc_rdy_1,
   input  logic                               mshr_rel_vld_0,
   input  logic                               mshr_rel_vld_1,
   input  logic [ENTRY_IDX_WIDTH-1:0]         mshr_rel_idx_0,
   input  logic [ENTRY_IDX_WIDTH-1:0]         mshr_rel_idx_1,
   output logic [$clog2(ENTRY_NUM+1)-1:0]     free_cnt,
   output logic                               alloc_err
);

   localparam int CNT_W = $clog2(ENTRY_NUM + 1);
   localparam logic [ENTRY_IDX_WIDTH:0] ENTRY_NUM_W = (ENTRY_IDX_WIDTH + 1)'(ENTRY_NUM);

   logic [ENTRY_NUM-1:0] free_map_q, free_map_d;
   logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
   logic [ENTRY_NUM-1:0] alloc_mask, kept_map;
   logic                 fire_0, fire_1;
   logic                 in_range_0, in_range_1;
   logic                 take_0, take_1;
   logic                 new_0, new_1;
   logic                 bad_0, bad_1;
   logic [1:0]           hits;

   // Handshake: slot k transfers on a cycle where vld_k && rdy_k. vld_k and idx_k come
   // only from registered state, so the arbiter may freely gate rdy_k on vld_k.
   always_comb begin
      mshr_alloc_idx_0 = '0;
      mshr_alloc_idx_1 = '0;
      hits             = 2'd0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (free_map_q[i]) begin
            if (hits == 2'd0) mshr_alloc_idx_0 = ENTRY_IDX_WIDTH'(i);
            else if (hits == 2'd1) mshr_alloc_idx_1 = ENTRY_IDX_WIDTH'(i);
            if (hits != 2'd2) hits = hits + 2'd1;
         end
      end
   end

   assign mshr_alloc_vld_0 = (free_cnt_q != '0);
   assign mshr_alloc_vld_1 = (free_cnt_q >= CNT_W'(2));
   assign free_cnt         = free_cnt_q;

   assign fire_0     = mshr_alloc_vld_0 & mshr_alloc_rdy_0;
   assign fire_1     = mshr_alloc_vld_1 & mshr_alloc_rdy_1;
   assign in_range_0 = ({1'b0, mshr_rel_idx_0} < ENTRY_NUM_W);
   assign in_range_1 = ({1'b0, mshr_rel_idx_1} < ENTRY_NUM_W);

   always_comb begin
      alloc_mask = '0;
      if (fire_0) alloc_mask[mshr_alloc_idx_0] = 1'b1;
      if (fire_1) alloc_mask[mshr_alloc_idx_1] = 1'b1;
   end

   assign kept_map = free_map_q & ~alloc_mask;

`ifdef VEC_CACHE_MSHR_ALLOC_CHK_EN
   // An offending release is dropped entirely; port 1 is the offender on an equal-index pair.
   assign bad_0  = mshr_rel_vld_0 & (~in_range_0 | free_map_q[mshr_rel_idx_0]);
   assign bad_1  = mshr_rel_vld_1 & (~in_range_1 | free_map_q[mshr_rel_idx_1] |
                   (mshr_rel_vld_0 & (mshr_rel_idx_0 == mshr_rel_idx_1)));
   assign take_0 = mshr_rel_vld_0 & ~bad_0;
   assign take_1 = mshr_rel_vld_1 & ~bad_1;
`else
   assign bad_0  = 1'b0;
   assign bad_1  = 1'b0;
   assign take_0 = mshr_rel_vld_0 & in_range_0;
   assign take_1 = mshr_rel_vld_1 & in_range_1 &
                   ~(take_0 & (mshr_rel_idx_0 == mshr_rel_idx_1));
`endif

   // Only releases that actually flip a bit to free move the counter, keeping it equal to popcount.
   assign new_0 = take_0 & ~kept_map[mshr_rel_idx_0];
   assign new_1 = take_1 & ~kept_map[mshr_rel_idx_1];

   always_comb begin
      free_map_d = kept_map;
      if (take_0) free_map_d[mshr_rel_idx_0] = 1'b1;
      if (take_1) free_map_d[mshr_rel_idx_1] = 1'b1;
      free_cnt_d = free_cnt_q - CNT_W'(fire_0) - CNT_W'(fire_1)
                   + CNT_W'(new_0) + CNT_W'(new_1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         free_map_q <= {ENTRY_NUM{1'b1}};
         free_cnt_q <= CNT_W'(ENTRY_NUM);
      end else begin
         free_map_q <= free_map_d;
         free_cnt_q <= free_cnt_d;
      end
   end

`ifdef VEC_CACHE_MSHR_ALLOC_CHK_EN
   logic alloc_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) alloc_err_q <= 1'b0;
      else        alloc_err_q <= alloc_err_q | bad_0 | bad_1;
   end

   assign alloc_err = alloc_err_q;
`else
   assign alloc_err = bad_0 | bad_1;
`endif

endmodule
